id_ex_stage: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection, bubble insertion and flush handling. It captures the decoded control bundle from the instruction-decode controller, together with operands and register indices, and presents them to the execute stage one cycle later. It raises `stall` to freeze the PC and the IF/ID register while a load-use hazard is pending, and it keeps a saturating count of inserted stall bubbles for performance analysis.

---
 rtl/riscv_pipe_pkg.sv | 37 +++
 rtl/load_use_detect.sv | 16 +
 rtl/id_ex_stage.sv | 106 ++++++++++
 tb/tb_id_ex_stage.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types: decoded control bundle, ALUOp encodings, opcodes
// and the ID/EX advance decision.
package riscv_pipe_pkg;

   typedef struct packed {
      logic       ALUSrc;
      logic       MemtoReg;
      logic       RegWrite;
      logic       MemRead;
      logic       MemWrite;
      logic [1:0] ALUOp;
      logic       Branch;
      logic       EhJAL;
      logic       EhJALR;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

   localparam logic [1:0] ALUOP_MEM   = 2'b00;
   localparam logic [1:0] ALUOP_BR    = 2'b01;
   localparam logic [1:0] ALUOP_ARITH = 2'b10;

   localparam logic [6:0] OPC_RTYPE = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE = 7'b0010011;
   localparam logic [6:0] OPC_LW    = 7'b0000011;
   localparam logic [6:0] OPC_SW    = 7'b0100011;
   localparam logic [6:0] OPC_BR    = 7'b1100011;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;

   typedef enum logic [1:0] {
      ADV_NORMAL,
      ADV_HAZARD,
      ADV_FLUSH
   } adv_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection: a load in EX whose destination feeds either
// source of the ID instruction. x0 never creates a dependency.
module load_use_detect (
   input  logic       ex_memread,
   input  logic [4:0] ex_rd,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   output logic       hazard
);

   always_comb begin
      hazard = ex_memread && (ex_rd != 5'd0) &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2));
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, bubble insertion on hazard or
// flush, and a saturating count of load-use bubbles.
module id_ex_stage
   import riscv_pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned PC_W   = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  ctrl_t             id_ctrl,
   input  logic [PC_W-1:0]   id_pc,
   input  logic [DATA_W-1:0] id_rd1,
   input  logic [DATA_W-1:0] id_rd2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic [4:0]        id_rd,
   input  logic [3:0]        id_funct,
   input  logic              flush,
   output ctrl_t             ex_ctrl,
   output logic [PC_W-1:0]   ex_pc,
   output logic [DATA_W-1:0] ex_rd1,
   output logic [DATA_W-1:0] ex_rd2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [4:0]        ex_rs1,
   output logic [4:0]        ex_rs2,
   output logic [4:0]        ex_rd,
   output logic [3:0]        ex_funct,
   output logic              stall,
   output logic [CNT_W-1:0]  bubble_cnt
);

   ctrl_t             ex_ctrl_q, ex_ctrl_d;
   logic [PC_W-1:0]   ex_pc_q;
   logic [DATA_W-1:0] ex_rd1_q, ex_rd2_q, ex_imm_q;
   logic [4:0]        ex_rs1_q, ex_rs2_q, ex_rd_q;
   logic [3:0]        ex_funct_q;
   logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
   logic              hazard;
   adv_e              adv;

   load_use_detect u_load_use_detect (
      .ex_memread (ex_ctrl_q.MemRead),
      .ex_rd      (ex_rd_q),
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .hazard     (hazard)
   );

   // Flush wins over the hazard: the ID instruction is dead, so holding it
   // upstream would be pointless and the bubble is not a load-use bubble.
   always_comb begin
      adv = ADV_NORMAL;
      if (flush) begin
         adv = ADV_FLUSH;
      end else if (hazard) begin
         adv = ADV_HAZARD;
      end
      stall        = (adv == ADV_HAZARD);
      ex_ctrl_d    = (adv == ADV_NORMAL) ? id_ctrl : CTRL_NOP;
      bubble_cnt_d = bubble_cnt_q;
      if (stall && (bubble_cnt_q != '1)) begin
         bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_ctrl_q    <= CTRL_NOP;
         ex_pc_q      <= '0;
         ex_rd1_q     <= '0;
         ex_rd2_q     <= '0;
         ex_imm_q     <= '0;
         ex_rs1_q     <= '0;
         ex_rs2_q     <= '0;
         ex_rd_q      <= '0;
         ex_funct_q   <= '0;
         bubble_cnt_q <= '0;
      end else begin
         ex_ctrl_q    <= ex_ctrl_d;
         ex_pc_q      <= id_pc;
         ex_rd1_q     <= id_rd1;
         ex_rd2_q     <= id_rd2;
         ex_imm_q     <= id_imm;
         ex_rs1_q     <= id_rs1;
         ex_rs2_q     <= id_rs2;
         ex_rd_q      <= id_rd;
         ex_funct_q   <= id_funct;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign ex_ctrl    = ex_ctrl_q;
   assign ex_pc      = ex_pc_q;
   assign ex_rd1     = ex_rd1_q;
   assign ex_rd2     = ex_rd2_q;
   assign ex_imm     = ex_imm_q;
   assign ex_rs1     = ex_rs1_q;
   assign ex_rs2     = ex_rs2_q;
   assign ex_rd      = ex_rd_q;
   assign ex_funct   = ex_funct_q;
   assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX state is queued when ID is
// driven and compared after the capturing edge.
module tb_id_ex_stage;
   import riscv_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   ctrl_t       id_ctrl;
   logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [3:0]  id_funct;
   logic        flush;
   ctrl_t       ex_ctrl;
   logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [3:0]  ex_funct;
   logic        stall;
   logic [3:0]  bubble_cnt;

   id_ex_stage #(.DATA_W(32), .PC_W(32), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .id_ctrl(id_ctrl), .id_pc(id_pc),
      .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_rs1(id_rs1),
      .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct), .flush(flush),
      .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
      .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_funct(ex_funct), .stall(stall), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  ctrl;
      logic [31:0] pc, rd1, rd2, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [3:0]  funct;
      logic [3:0]  cnt;
   } exp_t;

   exp_t sb[$];

   // Control bundles written out bit by bit: {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,ALUOp,Branch,JAL,JALR}
   localparam logic [9:0] C_RTYPE = 10'b0_0_1_0_0_10_0_0_0;
   localparam logic [9:0] C_LW    = 10'b1_1_1_1_0_00_0_0_0;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   logic        m_memread;
   logic [4:0]  m_rd;
   logic [3:0]  m_cnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctrl"}, 64'(ex_ctrl), 64'd0);
      chk({tag, "_pc"}, 64'(ex_pc), 64'd0);
      chk({tag, "_rd1"}, 64'(ex_rd1), 64'd0);
      chk({tag, "_rd2"}, 64'(ex_rd2), 64'd0);
      chk({tag, "_imm"}, 64'(ex_imm), 64'd0);
      chk({tag, "_idx"}, 64'({ex_rs1, ex_rs2, ex_rd, ex_funct}), 64'd0);
      chk({tag, "_stall"}, 64'(stall), 64'd0);
      chk({tag, "_cnt"}, 64'(bubble_cnt), 64'd0);
   endtask

   task automatic model_reset();
      m_memread = 1'b0;
      m_rd      = 5'd0;
      m_cnt     = 4'd0;
   endtask

   // Drive one ID instruction, check stall in-cycle, then check EX after the edge.
   task automatic step(input logic [9:0] c, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] d1, input logic fl);
      exp_t e;
      logic hz;
      logic [3:0] fn;
      @(negedge clk);
      fn = 4'($urandom);
      id_ctrl = c; id_pc = $urandom; id_rd1 = d1; id_rd2 = $urandom; id_imm = $urandom;
      id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_funct = fn; flush = fl;
      #1;
      hz = m_memread && (m_rd != 5'd0) && (m_rd == rs1 || m_rd == rs2);
      chk("stall", 64'(stall), 64'(hz && !fl));
      if (hz && !fl && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
      e.ctrl = (hz || fl) ? 10'd0 : c;
      e.pc = id_pc; e.rd1 = d1; e.rd2 = id_rd2; e.imm = id_imm;
      e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.funct = fn; e.cnt = m_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("ex_ctrl", 64'(ex_ctrl), 64'(e.ctrl));
      chk("ex_pc", 64'(ex_pc), 64'(e.pc));
      chk("ex_rd1", 64'(ex_rd1), 64'(e.rd1));
      chk("ex_rd2", 64'(ex_rd2), 64'(e.rd2));
      chk("ex_imm", 64'(ex_imm), 64'(e.imm));
      chk("ex_rs1", 64'(ex_rs1), 64'(e.rs1));
      chk("ex_rs2", 64'(ex_rs2), 64'(e.rs2));
      chk("ex_rd", 64'(ex_rd), 64'(e.rd));
      chk("ex_funct", 64'(ex_funct), 64'(e.funct));
      chk("bubble_cnt", 64'(bubble_cnt), 64'(e.cnt));
      m_memread = e.ctrl[6];
      m_rd      = e.rd;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      model_reset();
      reset = 1'b1; flush = 1'b0;
      id_ctrl = '0; id_pc = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
      id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_funct = '0;

      // Reset held with random ID inputs and the clock running
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         r = $urandom;
         id_ctrl = r[9:0]; id_pc = $urandom; id_rd1 = $urandom; id_rd2 = $urandom;
         id_imm = $urandom; id_rs1 = r[14:10]; id_rs2 = r[19:15]; id_rd = r[24:20];
         id_funct = r[28:25];
         #1 chk_all_zero("reset");
      end
      @(posedge clk);
      #1 reset = 1'b0;

      // Normal flow
      step(C_RTYPE, 5'd1, 5'd2, 5'd5, 32'h1234, 1'b0);
      step(C_RTYPE, 5'd6, 5'd7, 5'd8, $urandom, 1'b0);

      // Load-use on rs2, then the held instruction proceeds
      step(C_LW, 5'd1, 5'd2, 5'd3, $urandom, 1'b0);
      step(C_RTYPE, 5'd4, 5'd3, 5'd9, $urandom, 1'b0);
      step(C_RTYPE, 5'd4, 5'd3, 5'd9, $urandom, 1'b0);

      // Flush overrides the hazard
      step(C_LW, 5'd1, 5'd2, 5'd3, $urandom, 1'b0);
      step(C_RTYPE, 5'd4, 5'd3, 5'd9, $urandom, 1'b1);

      // x0 destination load and non-load producer never stall
      step(C_LW, 5'd1, 5'd2, 5'd0, $urandom, 1'b0);
      step(C_RTYPE, 5'd0, 5'd5, 5'd9, $urandom, 1'b0);
      step(C_RTYPE, 5'd1, 5'd2, 5'd3, $urandom, 1'b0);
      step(C_RTYPE, 5'd3, 5'd0, 5'd9, $urandom, 1'b0);

      // Back-to-back dependent loads
      step(C_LW, 5'd1, 5'd2, 5'd3, $urandom, 1'b0);
      step(C_LW, 5'd3, 5'd0, 5'd4, $urandom, 1'b0);
      step(C_LW, 5'd3, 5'd0, 5'd4, $urandom, 1'b0);
      step(C_RTYPE, 5'd4, 5'd0, 5'd6, $urandom, 1'b0);
      step(C_RTYPE, 5'd4, 5'd0, 5'd6, $urandom, 1'b0);

      // Twenty hazards drive the 4-bit counter into saturation
      for (int i = 0; i < 20; i++) begin
         step(C_LW, 5'd1, 5'd2, 5'd3, $urandom, 1'b0);
         step(C_RTYPE, 5'd0, 5'd3, 5'd7, $urandom, 1'b0);
      end
      chk("saturated", 64'(bubble_cnt), 64'd15);

      // Reset asserted between edges while stalled clears everything at once
      step(C_LW, 5'd1, 5'd2, 5'd3, $urandom, 1'b0);
      @(negedge clk);
      id_ctrl = C_RTYPE; id_rs1 = 5'd3; id_rs2 = 5'd0; flush = 1'b0;
      #1 chk("pre_reset_stall", 64'(stall), 64'd1);
      #1 reset = 1'b1;
      #1 chk_all_zero("async_reset");
      @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      step(C_RTYPE, 5'd1, 5'd2, 5'd5, $urandom, 1'b0);

      // Random mix against the model
      for (int i = 0; i < 60; i++) begin
         r = $urandom;
         step(r[9:0], 5'(r[11:10]), 5'(r[13:12]), 5'(r[15:14]), $urandom, (r[17:16] == 2'b00));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
